// File: rtl/io_pins_snapshot_fifo.sv
// Synchronised pin-bus capture into a DEPTH-slot snapshot FIFO, streamed out byte-serially.
// Optional feature macro: IO_PINS_CHANGE_TRIG_EN (auto-capture whenever the synced bus changes).
module io_pins_snapshot_fifo #(
    parameter int  N_PINS      = 132,
    parameter int  DEPTH       = 4,
    parameter int  SYNC_STAGES = 2,
    localparam int N_BYTES     = (N_PINS + 7) / 8,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic              CLK50,
    input  logic              RST,
    input  logic [N_PINS-1:0] io_pins,
    input  logic              write_enable,
    input  logic              rd_ready,
    input  logic              clr_overflow,
    output logic              rd_valid,
    output logic [7:0]        rd_byte,
    output logic              rd_last,
    output logic [CW-1:0]     snap_count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam int PW = N_BYTES * 8;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    logic [N_PINS-1:0] sync_q [SYNC_STAGES];
    logic [N_PINS-1:0] sync_pins;
    logic [N_PINS-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idx_d;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              full_q;
    logic              empty_q;
    logic              ovf_q;
    state_t            state_q;
    state_t            state_d;
    logic              cap_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic              last_beat;
    logic [PW-1:0]     head_pad;

    assign sync_pins = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK50) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= io_pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

`ifdef IO_PINS_CHANGE_TRIG_EN
    // ref_q only follows accepted captures, so a dropped change keeps retrying.
    logic [N_PINS-1:0] ref_q;

    always_ff @(posedge CLK50) begin
        if (RST) begin
            ref_q <= '0;
        end else if (push) begin
            ref_q <= sync_pins;
        end
    end

    assign cap_req = write_enable | (sync_pins != ref_q);
`else
    assign cap_req = write_enable;
`endif

    assign last_beat = (idx_q == IW'(N_BYTES - 1));
    assign pop       = (state_q == STREAM) && rd_ready && last_beat;
    assign push      = cap_req && (!full_q || pop);
    assign drop      = cap_req && !push;
    assign count_d   = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge CLK50) begin
        if (!RST && push) begin
            mem_q[wr_ptr_q] <= sync_pins;
        end
    end

    always_ff @(posedge CLK50) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            state_q  <= IDLE;
            idx_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
            empty_q <= (count_d == '0);
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clr_overflow) begin
                ovf_q <= 1'b0;
            end
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rd_valid = 1'b0;
        rd_byte  = 8'h00;
        rd_last  = 1'b0;
        head_pad = '0;
        head_pad[N_PINS-1:0] = mem_q[rd_ptr_q];
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (!empty_q) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                rd_valid = 1'b1;
                rd_byte  = head_pad[{idx_q, 3'b000} +: 8];
                rd_last  = last_beat;
                if (rd_ready) begin
                    if (last_beat) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign snap_count = count_q;
    assign full       = full_q;
    assign empty      = empty_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_io_pins_snapshot_fifo.sv
// Directed bench for io_pins_snapshot_fifo at default parameters.
// Change-trigger scenario is selected when IO_PINS_CHANGE_TRIG_EN is defined.
module tb_io_pins_snapshot_fifo;

    localparam int N_PINS      = 132;
    localparam int DEPTH       = 4;
    localparam int SYNC_STAGES = 2;
    localparam int N_BYTES     = 17;
    localparam int CW          = 3;
    localparam logic [N_PINS-1:0] BASIC = 132'h0123456789ABCDEF;

    logic              CLK50 = 1'b0;
    logic              RST;
    logic [N_PINS-1:0] io_pins;
    logic              write_enable;
    logic              rd_ready;
    logic              clr_overflow;
    logic              rd_valid;
    logic [7:0]        rd_byte;
    logic              rd_last;
    logic [CW-1:0]     snap_count;
    logic              full;
    logic              empty;
    logic              overflow;

    int total  = 0;
    int passed = 0;

    logic [7:0] exp_basic [N_BYTES];
    logic [7:0] got [N_BYTES];
    bit         tmo;

    io_pins_snapshot_fifo #(
        .N_PINS     (N_PINS),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK50       (CLK50),
        .RST         (RST),
        .io_pins     (io_pins),
        .write_enable(write_enable),
        .rd_ready    (rd_ready),
        .clr_overflow(clr_overflow),
        .rd_valid    (rd_valid),
        .rd_byte     (rd_byte),
        .rd_last     (rd_last),
        .snap_count  (snap_count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    always #10 CLK50 = ~CLK50;

    task automatic step();
        @(posedge CLK50);
        #1;
    endtask

    task automatic capture(input logic [N_PINS-1:0] v);
        io_pins = v;
        repeat (SYNC_STAGES + 1) step();
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    // Collects one whole snapshot; no checking here.
    task automatic read_snap(output logic [7:0] b [N_BYTES], output bit to);
        rd_ready = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rd_valid) begin
                to = 1'b0;
                break;
            end
            step();
        end
        for (int k = 0; k < N_BYTES; k++) begin
            b[k] = rd_byte;
            step();
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) step();
        total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %0h want 0", rd_valid); else passed++;
        total++; if (rd_byte !== 8'h00) $display("FAIL reset_rd_byte got %0h want 0", rd_byte); else passed++;
        total++; if (rd_last !== 1'b0) $display("FAIL reset_rd_last got %0h want 0", rd_last); else passed++;
        total++; if (snap_count !== 3'd0) $display("FAIL reset_count got %0d want 0", snap_count); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %0h want 0", full); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got %0h want 1", empty); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0h want 0", overflow); else passed++;
        RST = 1'b0;
        step();
    endtask

    task automatic test_basic();
        rd_ready = 1'b1;
        capture(BASIC);
        total++; if (snap_count !== 3'd1) $display("FAIL basic_count1 got %0d want 1", snap_count); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL basic_first_latency got %0h want 0", rd_valid); else passed++;
        step();
        for (int k = 0; k < N_BYTES; k++) begin
            total++; if (rd_valid !== 1'b1) $display("FAIL basic_valid[%0d] got %0h want 1", k, rd_valid); else passed++;
            total++; if (rd_byte !== exp_basic[k]) $display("FAIL basic_byte[%0d] got %0h want %0h", k, rd_byte, exp_basic[k]); else passed++;
            total++; if (rd_last !== (k == N_BYTES - 1)) $display("FAIL basic_last[%0d] got %0h want %0h", k, rd_last, (k == N_BYTES - 1)); else passed++;
            step();
        end
        total++; if (snap_count !== 3'd0) $display("FAIL basic_count0 got %0d want 0", snap_count); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL basic_empty got %0h want 1", empty); else passed++;
        total++; if (rd_valid !== 1'b0) $display("FAIL basic_idle got %0h want 0", rd_valid); else passed++;
    endtask

    task automatic test_order_wrap();
        for (int v = 1; v <= 6; v++) begin
            capture(N_PINS'(v));
            read_snap(got, tmo);
            total++; if (tmo !== 1'b0) $display("FAIL wrap_timeout[%0d] got %0h want 0", v, tmo); else passed++;
            total++; if (got[0] !== 8'(v)) $display("FAIL wrap_byte0[%0d] got %0h want %0h", v, got[0], 8'(v)); else passed++;
        end
        total++; if (overflow !== 1'b0) $display("FAIL wrap_overflow got %0h want 0", overflow); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL wrap_empty got %0h want 1", empty); else passed++;
    endtask

    task automatic test_overflow();
        rd_ready = 1'b0;
        for (int v = 10; v <= 13; v++) capture(N_PINS'(v));
        total++; if (full !== 1'b1) $display("FAIL ovf_full got %0h want 1", full); else passed++;
        total++; if (snap_count !== 3'd4) $display("FAIL ovf_count4 got %0d want 4", snap_count); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_early got %0h want 0", overflow); else passed++;
        capture(N_PINS'(14));
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set got %0h want 1", overflow); else passed++;
        total++; if (snap_count !== 3'd4) $display("FAIL ovf_count_hold got %0d want 4", snap_count); else passed++;
        for (int v = 10; v <= 13; v++) begin
            read_snap(got, tmo);
            total++; if (tmo !== 1'b0) $display("FAIL ovf_timeout[%0d] got %0h want 0", v, tmo); else passed++;
            total++; if (got[0] !== 8'(v)) $display("FAIL ovf_drain[%0d] got %0h want %0h", v, got[0], 8'(v)); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL ovf_empty got %0h want 1", empty); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0h want 1", overflow); else passed++;
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got %0h want 0", overflow); else passed++;
        rd_ready = 1'b0;
        io_pins = N_PINS'(8'h33);
        repeat (SYNC_STAGES + 1) step();
        write_enable = 1'b1;
        repeat (4) step();
        clr_overflow = 1'b1;
        step();
        write_enable = 1'b0;
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %0h want 1", overflow); else passed++;
        total++; if (snap_count !== 3'd4) $display("FAIL ovf_refill got %0d want 4", snap_count); else passed++;
        clr_overflow = 1'b1;
        step();
        clr_overflow = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_snap(got, tmo);
            total++; if (got[0] !== 8'h33) $display("FAIL ovf_drain2[%0d] got %0h want 33", i, got[0]); else passed++;
        end
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clear2 got %0h want 0", overflow); else passed++;
    endtask

    task automatic test_push_pop_full();
        logic [7:0] want [4];
        want = '{8'h55, 8'h55, 8'h55, 8'h77};
        rd_ready = 1'b0;
        io_pins = N_PINS'(8'h55);
        repeat (SYNC_STAGES + 1) step();
        write_enable = 1'b1;
        repeat (4) step();
        write_enable = 1'b0;
        total++; if (full !== 1'b1) $display("FAIL pp_full got %0h want 1", full); else passed++;
        io_pins = N_PINS'(8'h77);
        repeat (SYNC_STAGES + 1) step();
        rd_ready = 1'b1;
        repeat (N_BYTES - 1) step();
        total++; if (rd_last !== 1'b1) $display("FAIL pp_at_last got %0h want 1", rd_last); else passed++;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
        total++; if (snap_count !== 3'd4) $display("FAIL pp_count got %0d want 4", snap_count); else passed++;
        total++; if (full !== 1'b1) $display("FAIL pp_full_after got %0h want 1", full); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL pp_overflow got %0h want 0", overflow); else passed++;
        for (int i = 0; i < 4; i++) begin
            read_snap(got, tmo);
            total++; if (got[0] !== want[i]) $display("FAIL pp_drain[%0d] got %0h want %0h", i, got[0], want[i]); else passed++;
        end
        total++; if (empty !== 1'b1) $display("FAIL pp_empty got %0h want 1", empty); else passed++;
    endtask

    task automatic test_back_to_back_reset();
        int k;
        int cyc;
        int stray;
        rd_ready = 1'b0;
        capture(BASIC);
        step();
        k = 0;
        cyc = 0;
        while (k < 5 && cyc < 100) begin
            rd_ready = (cyc % 2 == 1);
            total++; if (rd_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %0h want 1", cyc, rd_valid); else passed++;
            total++; if (rd_byte !== exp_basic[k]) $display("FAIL bp_byte[%0d] got %0h want %0h", k, rd_byte, exp_basic[k]); else passed++;
            step();
            if (rd_ready) k++;
            cyc++;
        end
        total++; if (k !== 5) $display("FAIL bp_progress got %0d want 5", k); else passed++;
        RST = 1'b1;
        rd_ready = 1'b1;
        step();
        RST = 1'b0;
        total++; if (rd_valid !== 1'b0) $display("FAIL rst_mid_valid got %0h want 0", rd_valid); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL rst_mid_empty got %0h want 1", empty); else passed++;
        total++; if (snap_count !== 3'd0) $display("FAIL rst_mid_count got %0d want 0", snap_count); else passed++;
        stray = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rd_valid) stray++;
        end
        total++; if (stray !== 0) $display("FAIL rst_mid_stray got %0d want 0", stray); else passed++;
    endtask

    task automatic test_no_change_trig();
        io_pins = N_PINS'(8'hA5);
        repeat (6) step();
        total++; if (empty !== 1'b1) $display("FAIL notrig_empty got %0h want 1", empty); else passed++;
        total++; if (snap_count !== 3'd0) $display("FAIL notrig_count got %0d want 0", snap_count); else passed++;
    endtask

    task automatic test_change_trig();
        logic [7:0] want [2];
        want = '{8'h01, 8'h00};
        for (int t = 0; t < 2; t++) begin
            rd_ready = 1'b0;
            io_pins = N_PINS'(want[t]);
            repeat (SYNC_STAGES + 1) step();
            total++; if (rd_valid !== 1'b0) $display("FAIL trig_early[%0d] got %0h want 0", t, rd_valid); else passed++;
            total++; if (snap_count !== 3'd1) $display("FAIL trig_count[%0d] got %0d want 1", t, snap_count); else passed++;
            step();
            total++; if (rd_valid !== 1'b1) $display("FAIL trig_valid[%0d] got %0h want 1", t, rd_valid); else passed++;
            read_snap(got, tmo);
            total++; if (got[0] !== want[t]) $display("FAIL trig_byte0[%0d] got %0h want %0h", t, got[0], want[t]); else passed++;
        end
        repeat (10) step();
        total++; if (empty !== 1'b1) $display("FAIL trig_steady_empty got %0h want 1", empty); else passed++;
        total++; if (snap_count !== 3'd0) $display("FAIL trig_steady_count got %0d want 0", snap_count); else passed++;
    endtask

    initial begin
        exp_basic = '{0: 8'hEF, 1: 8'hCD, 2: 8'hAB, 3: 8'h89,
                      4: 8'h67, 5: 8'h45, 6: 8'h23, 7: 8'h01, default: 8'h00};
        RST          = 1'b1;
        io_pins      = '0;
        write_enable = 1'b0;
        rd_ready     = 1'b0;
        clr_overflow = 1'b0;
        test_reset();
`ifdef IO_PINS_CHANGE_TRIG_EN
        test_change_trig();
`else
        test_basic();
        test_order_wrap();
        test_overflow();
        test_push_pop_full();
        test_back_to_back_reset();
        test_no_change_trig();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
